branch_resolve_bht: RTL and testbench

Parametrised branch resolution unit for the EX stage, paired with a 2-bit saturating branch history table (BHT) read by IF. Evaluates all six RV32I/RV64I conditional branches with correct signed/unsigned semantics, computes the target, and flags mispredictions against the IF-stage prediction. Results are registered once for the hazard/redirect logic. Counter state trains on every resolved branch, and saturating event counters support performance debug.

---
 rtl/branch_resolve_bht.sv | 95 +++++++++
 tb/tb_branch_resolve_bht.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_bht.sv
// EX-stage branch resolve (six RV conditions, target, mispredict) plus 2-bit saturating BHT and stat counters.
// Latency: results registered, valid one cycle after the resolve edge; pred_taken_o is a combinational table read.
// Backpressure: none; accepts one branch every cycle, flush_i kills the EX instruction in place.
module branch_resolve_bht #(
    parameter int          XLEN        = 32,
    parameter int          BHT_ENTRIES = 64,
    parameter logic [1:0]  CNT_INIT    = 2'b01,
    parameter int          STAT_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [XLEN-1:0]   pred_pc_i,
    output logic              pred_taken_o,
    input  logic              valid_i,
    input  logic              is_branch_i,
    input  logic [2:0]        funct_i,
    input  logic [XLEN-1:0]   data1_i,
    input  logic [XLEN-1:0]   data2_i,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [XLEN-1:0]   imm_i,
    input  logic              pred_taken_i,
    input  logic              flush_i,
    output logic              res_valid_o,
    output logic              taken_o,
    output logic              mispredict_o,
    output logic [XLEN-1:0]   redirect_pc_o,
    output logic              illegal_o,
    output logic [STAT_W-1:0] branch_cnt_o,
    output logic [STAT_W-1:0] mispred_cnt_o
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] upd_idx;
    logic             fire;
    logic             legal;
    logic             cond;
    logic [XLEN-1:0]  target;
    logic [XLEN-1:0]  fallthrough;
    logic             unused_pred_pc;

    assign pred_idx       = pred_pc_i[IDX_W+1:2];
    assign upd_idx        = pc_i[IDX_W+1:2];
    assign pred_taken_o   = bht[pred_idx][1];
    assign unused_pred_pc = ^{pred_pc_i[XLEN-1:IDX_W+2], pred_pc_i[1:0]};

    assign fire        = valid_i & is_branch_i & ~flush_i;
    assign target      = pc_i + imm_i;
    assign fallthrough = pc_i + XLEN'(4);

    always_comb begin
        legal = 1'b1;
        cond  = 1'b0;
        case (funct_i)
            3'b000:  cond = (data1_i == data2_i);
            3'b001:  cond = (data1_i != data2_i);
            3'b100:  cond = ($signed(data1_i) <  $signed(data2_i));
            3'b101:  cond = ($signed(data1_i) >= $signed(data2_i));
            3'b110:  cond = (data1_i <  data2_i);
            3'b111:  cond = (data1_i >= data2_i);
            default: legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= CNT_INIT;
            res_valid_o   <= 1'b0;
            taken_o       <= 1'b0;
            mispredict_o  <= 1'b0;
            redirect_pc_o <= '0;
            illegal_o     <= 1'b0;
            branch_cnt_o  <= '0;
            mispred_cnt_o <= '0;
        end else begin
            res_valid_o   <= fire;
            taken_o       <= fire & legal & cond;
            mispredict_o  <= fire & legal & (cond != pred_taken_i);
            illegal_o     <= fire & ~legal;
            redirect_pc_o <= !fire ? '0 : ((legal & cond) ? target : fallthrough);

            if (fire && legal) begin
                if (cond && bht[upd_idx] != 2'b11)
                    bht[upd_idx] <= bht[upd_idx] + 2'b01;
                else if (!cond && bht[upd_idx] != 2'b00)
                    bht[upd_idx] <= bht[upd_idx] - 2'b01;
                if (branch_cnt_o != {STAT_W{1'b1}})
                    branch_cnt_o <= branch_cnt_o + 1'b1;
                if (cond != pred_taken_i && mispred_cnt_o != {STAT_W{1'b1}})
                    mispred_cnt_o <= mispred_cnt_o + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_branch_resolve_bht.sv
// Randomized + directed bench for branch_resolve_bht: reference model predicts each cycle's registered
// result into a queue; a monitor pops one entry per clock and compares.
module tb_branch_resolve_bht;
    localparam int XLEN = 32;
    localparam int ENT  = 16;
    localparam int SW   = 4;
    localparam int SMAX = (1 << SW) - 1;

    logic            clk = 1'b0;
    logic            rst_i, pred_taken_o, valid_i, is_branch_i, pred_taken_i, flush_i;
    logic [2:0]      funct_i;
    logic [XLEN-1:0] pred_pc_i, data1_i, data2_i, pc_i, imm_i, redirect_pc_o;
    logic            res_valid_o, taken_o, mispredict_o, illegal_o;
    logic [SW-1:0]   branch_cnt_o, mispred_cnt_o;

    branch_resolve_bht #(.XLEN(XLEN), .BHT_ENTRIES(ENT), .CNT_INIT(2'b01), .STAT_W(SW)) dut (
        .clk_i(clk), .rst_i(rst_i), .pred_pc_i(pred_pc_i), .pred_taken_o(pred_taken_o),
        .valid_i(valid_i), .is_branch_i(is_branch_i), .funct_i(funct_i),
        .data1_i(data1_i), .data2_i(data2_i), .pc_i(pc_i), .imm_i(imm_i),
        .pred_taken_i(pred_taken_i), .flush_i(flush_i), .res_valid_o(res_valid_o),
        .taken_o(taken_o), .mispredict_o(mispredict_o), .redirect_pc_o(redirect_pc_o),
        .illegal_o(illegal_o), .branch_cnt_o(branch_cnt_o), .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       v, t, m, il;
        bit [31:0] rd;
        int       bc, mc;
    } exp_t;

    exp_t exp_q[$];
    int   ctr[ENT];
    int   n_branch, n_mispred;
    int   checks = 0, fails = 0;
    bit   done = 0;

    function automatic void chk(string name, longint act, longint req);
        checks++;
        if (act != req) begin
            fails++;
            $display("FAIL %s at %0t: got 0x%0h want 0x%0h", name, $time, act, req);
        end
    endfunction

    function automatic int idx_of(bit [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    // Drive one cycle's inputs at the falling edge, check the combinational prediction
    // against the pre-edge table, then advance the model to what the next rising edge produces.
    task automatic cycle(bit rst, bit vld, bit br, bit [2:0] f3, bit [31:0] a, bit [31:0] b,
                         bit [31:0] pc, bit [31:0] imm, bit pt, bit fl, bit [31:0] ppc);
        exp_t e;
        bit   legal, t;
        @(negedge clk);
        rst_i = rst; valid_i = vld; is_branch_i = br; funct_i = f3; data1_i = a; data2_i = b;
        pc_i = pc; imm_i = imm; pred_taken_i = pt; flush_i = fl; pred_pc_i = ppc;
        #1;
        chk("pred_taken", pred_taken_o, (ctr[idx_of(ppc)] >= 2) ? 1 : 0);
        e = '{v: 0, t: 0, m: 0, il: 0, rd: 0, bc: 0, mc: 0};
        if (rst) begin
            foreach (ctr[i]) ctr[i] = 1;
            n_branch = 0; n_mispred = 0;
        end else if (vld && br && !fl) begin
            legal = 1; t = 0;
            case (f3)
                3'd0: t = (a == b);
                3'd1: t = (a != b);
                3'd4: t = ($signed(a) < $signed(b));
                3'd5: t = !($signed(a) < $signed(b));
                3'd6: t = (a < b);
                3'd7: t = !(a < b);
                default: legal = 0;
            endcase
            e.v = 1; e.il = !legal; e.t = t;
            e.m = legal && (t != pt);
            e.rd = t ? 32'((longint'(pc) + longint'(imm)) % 64'h1_0000_0000)
                     : 32'((longint'(pc) + 4) % 64'h1_0000_0000);
            if (legal) begin
                ctr[idx_of(pc)] = t ? ((ctr[idx_of(pc)] + 1 > 3) ? 3 : ctr[idx_of(pc)] + 1)
                                    : ((ctr[idx_of(pc)] - 1 < 0) ? 0 : ctr[idx_of(pc)] - 1);
                if (n_branch < SMAX) n_branch++;
                if (e.m && n_mispred < SMAX) n_mispred++;
            end
        end
        e.bc = n_branch; e.mc = n_mispred;
        exp_q.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk); #1;
            if (exp_q.size() == 0) begin
                if (!done) begin
                    checks++; fails++;
                    $display("FAIL scoreboard at %0t: no expected entry", $time);
                end
            end else begin
                e = exp_q.pop_front();
                chk("res_valid", res_valid_o, e.v);
                chk("taken", taken_o, e.t);
                chk("mispredict", mispredict_o, e.m);
                chk("illegal", illegal_o, e.il);
                chk("redirect_pc", redirect_pc_o, e.rd);
                chk("branch_cnt", branch_cnt_o, e.bc);
                chk("mispred_cnt", mispred_cnt_o, e.mc);
            end
        end
    end

    initial begin : stim
        bit [31:0] a, b, pc, ppc;
        foreach (ctr[i]) ctr[i] = 1;
        n_branch = 0; n_mispred = 0;
        rst_i = 1; valid_i = 0; is_branch_i = 0; funct_i = 0; data1_i = 0; data2_i = 0;
        pc_i = 0; imm_i = 0; pred_taken_i = 0; flush_i = 0; pred_pc_i = 0;
        exp_q.push_back('{v: 0, t: 0, m: 0, il: 0, rd: 0, bc: 0, mc: 0});
        cycle(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        // Condition / target coverage
        cycle(0, 1, 1, 3'd0, 5, 5, 32'h100, 32'h20, 0, 0, 32'h100);
        cycle(0, 1, 1, 3'd4, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 0, 0, 32'h200);
        cycle(0, 1, 1, 3'd6, 32'hFFFF_FFFF, 1, 32'h200, 32'h10, 1, 0, 32'h200);
        cycle(0, 1, 1, 3'd5, 7, 7, 32'h300, 32'hFFFF_FFF0, 0, 0, 32'h300);
        cycle(0, 1, 1, 3'd7, 7, 7, 32'h304, 32'h8, 1, 0, 32'h304);
        // Training one entry to saturation then one not-taken step
        repeat (5) cycle(0, 1, 1, 3'd0, 1, 1, 32'h40, 32'h4, 1, 0, 32'h40);
        cycle(0, 1, 1, 3'd0, 1, 2, 32'h40, 32'h4, 1, 0, 32'h40);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        // Illegal funct3, flushed branch, address wrap
        cycle(0, 1, 1, 3'd2, 3, 3, 32'h40, 32'h4, 1, 0, 32'h40);
        cycle(0, 1, 1, 3'd3, 3, 3, 32'h80, 32'h4, 0, 0, 32'h80);
        cycle(0, 1, 1, 3'd1, 1, 2, 32'h40, 32'h4, 0, 1, 32'h40);
        cycle(0, 1, 1, 3'd0, 9, 9, 32'hFFFF_FFFC, 32'h8, 0, 0, 32'hFFFF_FFFC);
        cycle(0, 1, 1, 3'd1, 9, 9, 32'hFFFF_FFFC, 32'h8, 1, 0, 32'hFFFF_FFFC);
        // Mispredict counter saturation
        repeat (20) cycle(0, 1, 1, 3'd0, 4, 4, 32'h140, 32'h40, 0, 0, 32'h140);
        // Reset mid-stream, with a branch in EX that must be discarded
        cycle(1, 1, 1, 3'd0, 4, 4, 32'h40, 32'h40, 0, 0, 32'h40);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h140);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h40);
        // Random traffic with heavy index aliasing
        for (int n = 0; n < 3000; n++) begin
            a   = $urandom;
            b   = ($urandom_range(0, 3) == 0) ? a : (($urandom_range(0, 1) == 0) ? $urandom : a ^ 32'h8000_0000);
            pc  = ($urandom_range(0, 1) == 0) ? {$urandom_range(0, 63), 2'b00} : {$urandom} & ~32'h3;
            ppc = ($urandom_range(0, 1) == 0) ? pc : {$urandom_range(0, 63), 2'b00};
            cycle($urandom_range(0, 249) == 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0,
                  3'($urandom_range(0, 7)), a, b, pc, $urandom, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 7) == 0, ppc);
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        done = 1;
        if (exp_q.size() != 0) begin
            checks++; fails++;
            $display("FAIL scoreboard_drain: %0d entries left, want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
